// File: rtl/aes_key_pkg.sv
// rtl/aes_key_pkg.sv - shared types, widths and GF(2^8) helper for the AES-256 key schedule
package aes_key_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    SUB  = 2'd2
  } ks_state_e;

  localparam int           RK_W     = 128;
  localparam int           KEY_W    = 256;
  localparam int           NRK      = 15;
  localparam logic [3:0]   LAST_IDX = 4'(NRK - 1);
  localparam logic [7:0]   RCON0    = 8'h01;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword_reg.sv
// rtl/aes_subword_reg.sv - four byte S-boxes with a registered 32-bit output
// The register only updates on en so the result stays put for the consuming cycle.
module aes_subword_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [31:0] word_d;
  logic [31:0] word_q;

  // Byte b sits at bit offset (255-b)*8 since entry 0 is the leftmost literal byte.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  always_comb begin
    word_d = word_q;
    if (en) begin
      word_d = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                sbox(word_in[15:8]),  sbox(word_in[7:0])};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_out = word_q;

endmodule

// File: rtl/aes256_key_sched.sv
// rtl/aes256_key_sched.sv - iterative AES-256 key expansion streaming rk0..rk14
module aes256_key_sched
  import aes_key_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KEY_W-1:0]  key_in,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [RK_W-1:0]   rk_out,
  output logic [3:0]        rk_idx,
  output logic              rk_last
);

  ks_state_e       state_q, state_d;
  logic [RK_W-1:0] hi_q, hi_d;
  logic [RK_W-1:0] lo_q, lo_d;
  logic [RK_W-1:0] rk_out_q, rk_out_d;
  logic [3:0]      rk_idx_q, rk_idx_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            rk_valid_q, rk_valid_d;
  logic            busy_q, busy_d;

  logic            sub_en;
  logic [31:0]     sub_in;
  logic [31:0]     sub_word;
  logic [3:0]      next_idx;
  logic            type_a;
  logic            hs;
  logic [31:0]     t, n0, n1, n2, n3;

  aes_subword_reg u_subword (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sub_en),
    .word_in  (sub_in),
    .word_out (sub_word)
  );

  // Even-numbered round keys beyond rk1 start a fresh 256-bit block: RotWord + Rcon.
  assign next_idx = rk_idx_q + 4'd1;
  assign type_a   = ~next_idx[0];
  assign hs       = rk_valid_q & rk_ready;
  assign sub_in   = type_a ? {lo_q[23:0], lo_q[31:24]} : lo_q[31:0];

  assign t  = sub_word ^ (type_a ? {rcon_q, 24'h000000} : 32'h0);
  assign n0 = hi_q[127:96] ^ t;
  assign n1 = hi_q[95:64]  ^ n0;
  assign n2 = hi_q[63:32]  ^ n1;
  assign n3 = hi_q[31:0]   ^ n2;

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rk_out_d   = rk_out_q;
    rk_idx_d   = rk_idx_q;
    rcon_d     = rcon_q;
    rk_valid_d = rk_valid_q;
    busy_d     = busy_q;
    sub_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          hi_d       = key_in[255:128];
          lo_d       = key_in[127:0];
          rk_out_d   = key_in[255:128];
          rk_idx_d   = 4'd0;
          rcon_d     = RCON0;
          busy_d     = 1'b1;
          rk_valid_d = 1'b1;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (hs) begin
          if (rk_idx_q == LAST_IDX) begin
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end else if (rk_idx_q == 4'd0) begin
            // rk1 is the raw lower key half, so no expansion step is needed.
            rk_out_d = lo_q;
            rk_idx_d = 4'd1;
          end else begin
            rk_valid_d = 1'b0;
            sub_en     = 1'b1;
            state_d    = SUB;
          end
        end
      end
      SUB: begin
        rk_out_d   = {n0, n1, n2, n3};
        hi_d       = lo_q;
        lo_d       = {n0, n1, n2, n3};
        rk_idx_d   = next_idx;
        rk_valid_d = 1'b1;
        state_d    = EMIT;
        if (type_a) begin
          rcon_d = xtime(rcon_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      rk_out_q   <= '0;
      rk_idx_q   <= 4'd0;
      rcon_q     <= RCON0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rk_out_q   <= rk_out_d;
      rk_idx_q   <= rk_idx_d;
      rcon_q     <= rcon_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk_out   = rk_out_q;
  assign rk_idx   = rk_idx_q;
  assign rk_last  = (rk_idx_q == LAST_IDX);

endmodule

// File: tb/tb_aes256_key_sched.sv
// tb/tb_aes256_key_sched.sv - self-checking bench for aes256_key_sched against a word-level key expansion model
module tb_aes256_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_last;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [15];
  logic [127:0] got_rk [15];
  logic         got_last [15];
  int           hs_cyc [15];
  int           got_n, stall_err, idx_err, first_valid_cyc;
  bit           inj_done;

  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;

  aes256_key_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .rk_last  (rk_last)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] d = {v, v};
    return d[15-k -: 8];
  endfunction

  // S-box derived from first principles: multiplicative inverse then affine map.
  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = sub_word_m({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = sub_word_m(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int n = 0; n < 15; n++) exp_rk[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a falling edge; pulses start and collects every handshaken round key.
  task automatic run_sched(input logic [255:0] key, input int pct, input int inj_idx,
                           input logic [255:0] inj_key, input bit b2b);
    bit           pend = 0;
    bit           done = 0;
    logic [127:0] pout;
    logic [3:0]   pidx;
    got_n = 0; stall_err = 0; idx_err = 0; first_valid_cyc = -1; inj_done = 0;
    for (int n = 0; n < 15; n++) begin got_rk[n] = 'x; got_last[n] = 1'bx; hs_cyc[n] = -1; end
    key_in = key;
    start  = 1'b1;
    rk_ready = 1'b0;
    for (int cyc = 1; cyc <= 2000 && !done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (rk_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (rk_valid && pend && (rk_out !== pout || rk_idx !== pidx)) stall_err++;
      if (rk_valid && inj_idx >= 0 && rk_idx == 4'(inj_idx) && !inj_done) begin
        start = 1'b1; key_in = inj_key; inj_done = 1;
      end
      rk_ready = ($urandom_range(0, 99) < pct);
      if (rk_valid && rk_ready) begin
        if (rk_idx !== 4'(got_n)) idx_err++;
        got_rk[rk_idx] = rk_out;
        got_last[rk_idx] = rk_last;
        hs_cyc[rk_idx] = cyc;
        got_n++;
        pend = 0;
        if (rk_idx == 4'd14) begin
          done = 1;
          if (b2b) begin start = 1'b1; key_in = rand256(); end
        end
      end else begin
        pend = rk_valid;
        pout = rk_out;
        pidx = rk_idx;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, rk_valid, rk_last, rk_idx, rk_out} !== 135'd0)
      $display("FAIL reset_outputs: got busy=%b valid=%b last=%b idx=%0d out=%h, want all zero",
               busy, rk_valid, rk_last, rk_idx, rk_out);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed_key();
    bit bad_last = 0;
    model_expand(FIPS_KEY);
    run_sched(FIPS_KEY, 100, -1, '0, 0);
    n_checks++;
    if (got_n !== 15) $display("FAIL fixed_count: got %0d keys, want 15", got_n); else n_pass++;
    n_checks++;
    if (got_rk[0] !== 128'h000102030405060708090a0b0c0d0e0f)
      $display("FAIL fixed_rk0: got %h want 000102030405060708090a0b0c0d0e0f", got_rk[0]);
    else n_pass++;
    n_checks++;
    if (got_rk[1] !== 128'h101112131415161718191a1b1c1d1e1f)
      $display("FAIL fixed_rk1: got %h want 101112131415161718191a1b1c1d1e1f", got_rk[1]);
    else n_pass++;
    n_checks++;
    if (got_rk[2] !== 128'ha573c29fa176c498a97fce93a572c09c)
      $display("FAIL fixed_rk2: got %h want a573c29fa176c498a97fce93a572c09c", got_rk[2]);
    else n_pass++;
    n_checks++;
    if (got_rk[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36 || got_last[14] !== 1'b1)
      $display("FAIL fixed_rk14: got %h last=%b want 24fc79ccbf0979e9371ac23c6d68de36 last=1",
               got_rk[14], got_last[14]);
    else n_pass++;
    for (int n = 0; n < 14; n++) if (got_last[n] !== 1'b0) bad_last = 1;
    n_checks++;
    if (bad_last) $display("FAIL fixed_last_early: rk_last seen before rk14, want 0"); else n_pass++;
    for (int n = 0; n < 15; n++) begin
      n_checks++;
      if (got_rk[n] !== exp_rk[n]) $display("FAIL fixed_model_rk%0d: got %h want %h", n, got_rk[n], exp_rk[n]);
      else n_pass++;
    end
    n_checks++;
    if (first_valid_cyc !== 1) $display("FAIL start_latency: got %0d cycles want 1", first_valid_cyc); else n_pass++;
    n_checks++;
    if (hs_cyc[1] - hs_cyc[0] !== 1) $display("FAIL rk0_rk1_gap: got %0d want 1", hs_cyc[1] - hs_cyc[0]); else n_pass++;
    for (int n = 1; n < 14; n++) begin
      n_checks++;
      if (hs_cyc[n+1] - hs_cyc[n] !== 2)
        $display("FAIL step_gap_rk%0d: got %0d want 2", n, hs_cyc[n+1] - hs_cyc[n]);
      else n_pass++;
    end
    @(negedge clk);
    rk_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0)
      $display("FAIL busy_fall: got busy=%b valid=%b want 0 0", busy, rk_valid);
    else n_pass++;
  endtask

  task automatic test_random_ready();
    model_expand(FIPS_KEY);
    run_sched(FIPS_KEY, 30, -1, '0, 0);
    n_checks++;
    if (got_n !== 15 || idx_err !== 0) $display("FAIL rr_count: got %0d keys idx_err=%0d want 15 0", got_n, idx_err);
    else n_pass++;
    for (int n = 0; n < 15; n++) begin
      n_checks++;
      if (got_rk[n] !== exp_rk[n]) $display("FAIL rr_rk%0d: got %h want %h", n, got_rk[n], exp_rk[n]);
      else n_pass++;
    end
    n_checks++;
    if (stall_err !== 0) $display("FAIL rr_stall_stable: got %0d changes while stalled want 0", stall_err);
    else n_pass++;
    @(negedge clk);
    rk_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    model_expand(FIPS_KEY);
    run_sched(FIPS_KEY, 60, 5, rand256(), 0);
    n_checks++;
    if (inj_done !== 1'b1 || got_n !== 15) $display("FAIL busy_start_run: got inj=%b keys=%0d want 1 15", inj_done, got_n);
    else n_pass++;
    for (int n = 0; n < 15; n++) begin
      n_checks++;
      if (got_rk[n] !== exp_rk[n]) $display("FAIL busy_start_rk%0d: got %h want %h", n, got_rk[n], exp_rk[n]);
      else n_pass++;
    end
    @(negedge clk);
    rk_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    logic [255:0] k2;
    key_in = rand256(); start = 1'b1; rk_ready = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && !rk_valid && rk_idx == 4'd7) begin found = 1; break; end
    end
    n_checks++;
    if (!found) $display("FAIL mid_reach_sub7: got found=0 want 1"); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, rk_valid, rk_last, rk_idx, rk_out} !== 135'd0)
      $display("FAIL mid_reset_outputs: got busy=%b valid=%b last=%b idx=%0d out=%h want all zero",
               busy, rk_valid, rk_last, rk_idx, rk_out);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; rk_ready = 1'b0;
    @(negedge clk);
    k2 = rand256();
    model_expand(k2);
    run_sched(k2, 100, -1, '0, 0);
    n_checks++;
    if (first_valid_cyc !== 1 || got_rk[0] !== k2[255:128])
      $display("FAIL post_reset_rk0: got lat=%0d rk0=%h want 1 %h", first_valid_cyc, got_rk[0], k2[255:128]);
    else n_pass++;
    for (int n = 0; n < 15; n++) begin
      n_checks++;
      if (got_rk[n] !== exp_rk[n]) $display("FAIL post_reset_rk%0d: got %h want %h", n, got_rk[n], exp_rk[n]);
      else n_pass++;
    end
    @(negedge clk);
    rk_ready = 1'b0;
  endtask

  // Recovers the round constant each type-A step applied from the emitted keys.
  task automatic test_rcon();
    logic [31:0] rec;
    run_sched(rand256(), 70, -1, '0, 0);
    for (int n = 2; n <= 14; n += 2) begin
      rec = got_rk[n][127:96] ^ got_rk[n-2][127:96] ^ sub_word_m({got_rk[n-1][23:0], got_rk[n-1][31:24]});
      n_checks++;
      if (rec !== {8'(1 << (n/2 - 1)), 24'h0})
        $display("FAIL rcon_rk%0d: got %h want %h", n, rec, {8'(1 << (n/2 - 1)), 24'h0});
      else n_pass++;
    end
    @(negedge clk);
    rk_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [255:0] k1, k2;
    k1 = rand256();
    model_expand(k1);
    run_sched(k1, 100, -1, '0, 1);
    for (int n = 0; n < 15; n++) begin
      n_checks++;
      if (got_rk[n] !== exp_rk[n]) $display("FAIL b2b_first_rk%0d: got %h want %h", n, got_rk[n], exp_rk[n]);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0)
      $display("FAIL b2b_last_start_ignored: got busy=%b valid=%b want 0 0", busy, rk_valid);
    else n_pass++;
    k2 = rand256();
    model_expand(k2);
    run_sched(k2, 100, -1, '0, 0);
    n_checks++;
    if (first_valid_cyc !== 1) $display("FAIL b2b_latency: got %0d want 1", first_valid_cyc); else n_pass++;
    for (int n = 0; n < 15; n++) begin
      n_checks++;
      if (got_rk[n] !== exp_rk[n]) $display("FAIL b2b_second_rk%0d: got %h want %h", n, got_rk[n], exp_rk[n]);
      else n_pass++;
    end
    @(negedge clk);
    rk_ready = 1'b0;
  endtask

  initial begin
    init_sbox();
    test_reset();
    test_fixed_key();
    test_random_ready();
    test_start_ignored();
    test_reset_mid();
    test_rcon();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
